// File: rtl/ram_1r1w_arbiter_if.sv
// Requester-side bus of ram_1r1w_arbiter: two valid/ready request ports and a
// shared, requester-tagged read response.
interface ram_1r1w_arbiter_if #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 16
);
    localparam int unsigned addr_width_lp = (depth_p > 1) ? $clog2(depth_p) : 1;

    logic [1:0]                 req_valid_i;
    logic [1:0]                 req_ready_o;
    logic [1:0]                 req_we_i;
    logic [2*addr_width_lp-1:0] req_addr_i;
    logic [2*width_p-1:0]       req_data_i;
    logic [1:0]                 rsp_valid_o;
    logic [width_p-1:0]         rsp_data_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/ram_1r1w_arbiter.sv
// Round-robin arbiter sharing one synchronous 1R1W RAM between two requesters,
// with an optional post-reset sequencer that zeroes every RAM word.
module ram_1r1w_arbiter #(
    parameter int unsigned width_p      = 8,
    parameter int unsigned depth_p      = 16,
    parameter int unsigned init_clear_p = 1,
    localparam int unsigned addr_width_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    ram_1r1w_arbiter_if.slave        req_if,
    output logic                     busy_o,
    output logic                     ram_wr_valid_o,
    output logic [addr_width_lp-1:0] ram_wr_addr_o,
    output logic [width_p-1:0]       ram_wr_data_o,
    output logic [addr_width_lp-1:0] ram_rd_addr_o,
    input  logic [width_p-1:0]       ram_rd_data_i
);
    localparam logic [1:0] st_rst_wait = 2'd0;
    localparam logic [1:0] st_clear    = 2'd1;
    localparam logic [1:0] st_run      = 2'd2;

    logic [1:0]               state_q,     state_n;
    logic [addr_width_lp-1:0] clr_cnt_q,   clr_cnt_n;
    logic                     prio_q,      prio_n;
    logic [1:0]               rsp_valid_q, rsp_valid_n;
    logic [addr_width_lp-1:0] rd_addr_q,   rd_addr_n;

    logic [1:0]               grant;
    logic                     gsel;
    logic                     sel_we;
    logic [addr_width_lp-1:0] sel_addr;
    logic [width_p-1:0]       sel_data;
    logic                     clr_last;

    // Payload of whichever requester the grant vector points at
    assign gsel     = grant[1];
    assign sel_we   = gsel ? req_if.req_we_i[1] : req_if.req_we_i[0];
    assign sel_addr = gsel ? req_if.req_addr_i[2*addr_width_lp-1:addr_width_lp]
                           : req_if.req_addr_i[addr_width_lp-1:0];
    assign sel_data = gsel ? req_if.req_data_i[2*width_p-1:width_p]
                           : req_if.req_data_i[width_p-1:0];
    assign clr_last = (clr_cnt_q == addr_width_lp'(depth_p - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= st_rst_wait;
            clr_cnt_q   <= '0;
            prio_q      <= 1'b0;
            rsp_valid_q <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_n;
            clr_cnt_q   <= clr_cnt_n;
            prio_q      <= prio_n;
            rsp_valid_q <= rsp_valid_n;
            rd_addr_q   <= rd_addr_n;
        end
    end

    always_comb begin
        state_n        = state_q;
        clr_cnt_n      = clr_cnt_q;
        prio_n         = prio_q;
        rsp_valid_n    = '0;
        rd_addr_n      = rd_addr_q;
        grant          = '0;
        ram_wr_valid_o = 1'b0;
        ram_wr_addr_o  = '0;
        ram_wr_data_o  = '0;

        case (state_q)
            st_rst_wait: begin
                state_n = (init_clear_p != 0) ? st_clear : st_run;
            end

            st_clear: begin
                ram_wr_valid_o = 1'b1;
                ram_wr_addr_o  = clr_cnt_q;
                if (clr_last) begin
                    state_n = st_run;
                end else begin
                    clr_cnt_n = clr_cnt_q + addr_width_lp'(1);
                end
            end

            st_run: begin
                // Contention goes to prio_q; a lone requester always wins
                if (req_if.req_valid_i == 2'b11) begin
                    grant = prio_q ? 2'b10 : 2'b01;
                end else begin
                    grant = req_if.req_valid_i;
                end

                if (grant != 2'b00) begin
                    prio_n = ~gsel;
                    if (sel_we) begin
                        ram_wr_valid_o = 1'b1;
                        ram_wr_addr_o  = sel_addr;
                        ram_wr_data_o  = sel_data;
                    end else begin
                        rd_addr_n   = sel_addr;
                        rsp_valid_n = grant;
                    end
                end
            end

            default: begin
                state_n = st_rst_wait;
            end
        endcase
    end

    assign req_if.req_ready_o = grant;
    assign req_if.rsp_valid_o = rsp_valid_q;
    // RAM read data is only meaningful in the cycle after a granted read
    assign req_if.rsp_data_o  = (rsp_valid_q != 2'b00) ? ram_rd_data_i : '0;
    assign ram_rd_addr_o      = rd_addr_n;
    assign busy_o             = (state_q != st_run);
endmodule
